// File: rtl/mul4s_pkg.sv
// mul4s_pkg: shared definitions for the signed dot-product accumulator.
//   PROD_W      width of one signed product from the 4x4 multiplier array
//   dot_state_t accumulate / hold-result states of the dot-product FSM
//   sext_prod   sign-extends a product to 32 bits; callers cast down to ACC_W
package mul4s_pkg;

    localparam int PROD_W = 8;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } dot_state_t;

    // Widen to 32 bits so one function serves every ACC_W (8..32);
    // the caller narrows with a size cast.
    function automatic logic signed [31:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return 32'(p);
    endfunction

endpackage

// File: rtl/mul4s_acc_add.sv
// mul4s_acc_add: combinational ACC_W-bit add of the running sum and one
// sign-extended product.
//   i_acc   running signed sum
//   i_prod  signed product (PROD_W bits)
//   o_sum   next sum (wrapped, or clamped when MUL4S_ACC_SAT_EN is defined)
//   o_sat   the add clamped (always 0 without MUL4S_ACC_SAT_EN)
// Optional feature macro: MUL4S_ACC_SAT_EN (saturating add).
module mul4s_acc_add
    import mul4s_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic signed [PROD_W-1:0] i_prod,
    output logic signed [ACC_W-1:0]  o_sum,
    output logic                     o_sat
);

    logic signed [ACC_W-1:0] w_prod;

    assign w_prod = ACC_W'(sext_prod(i_prod));

`ifdef MUL4S_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // One guard bit: the two top bits disagree exactly when the true sum
    // left the signed ACC_W range; the guard bit then gives the direction.
    logic [ACC_W:0] w_wide;
    logic           w_ovf;

    assign w_wide = {i_acc[ACC_W-1], i_acc} + {w_prod[ACC_W-1], w_prod};
    assign w_ovf  = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    assign o_sum  = w_ovf ? (w_wide[ACC_W] ? SAT_MIN : SAT_MAX) : w_wide[ACC_W-1:0];
    assign o_sat  = w_ovf;
`else
    assign o_sum = i_acc + w_prod;
    assign o_sat = 1'b0;
`endif

endmodule

// File: rtl/mul4s_dot_acc.sv
// mul4s_dot_acc: accumulates a stream of signed 8-bit products into a signed
// dot-product and emits it after LEN terms or on a term flagged p_last.
//   clk, rst_n        clock, synchronous active-low reset
//   p_valid/p_ready   product handshake; p_data signed product, p_last closes sum
//   r_valid/r_ready   result handshake; r_data sum, r_count terms in sum,
//                     r_sat a clamp happened in this sum
// Optional feature macro: MUL4S_ACC_SAT_EN (saturating accumulation, r_sat).
module mul4s_dot_acc
    import mul4s_pkg::*;
#(
    parameter  int LEN   = 8,
    parameter  int ACC_W = 12,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     p_valid,
    output logic                     p_ready,
    input  logic signed [PROD_W-1:0] p_data,
    input  logic                     p_last,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic signed [ACC_W-1:0]  r_data,
    output logic [CNT_W-1:0]         r_count,
    output logic                     r_sat
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    dot_state_t              r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sat_acc;

    logic                    w_p_acc;
    logic                    w_r_acc;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_sat;
    logic                    w_sat_sum;

    // In OUT the input side only moves when the held result leaves the same cycle.
    assign p_ready = rst_n & ((r_state == ACC) | r_ready);
    assign w_p_acc = p_valid & p_ready;
    assign w_r_acc = r_valid & r_ready;

    // r_acc is zero whenever the FSM is in OUT, so the same adder yields
    // sext(p_data) for a product that opens the next sum.
    mul4s_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_acc  (r_acc),
        .i_prod (p_data),
        .o_sum  (w_sum),
        .o_sat  (w_sat)
    );

    // Sticky per-sum flag; r_sat_acc is cleared whenever a sum closes.
    assign w_sat_sum = r_sat_acc | w_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ACC;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sat_acc <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_count   <= '0;
            r_sat     <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_p_acc) begin
                        if (r_cnt == LAST_CNT || p_last) begin
                            r_data    <= w_sum;
                            r_count   <= r_cnt + 1'b1;
                            r_sat     <= w_sat_sum;
                            r_valid   <= 1'b1;
                            r_acc     <= '0;
                            r_cnt     <= '0;
                            r_sat_acc <= 1'b0;
                            r_state   <= OUT;
                        end else begin
                            r_acc     <= w_sum;
                            r_cnt     <= r_cnt + 1'b1;
                            r_sat_acc <= w_sat_sum;
                        end
                    end
                end
                OUT: begin
                    if (w_r_acc) begin
                        if (w_p_acc && p_last) begin
                            // Single-term sum closes immediately: replace the result.
                            r_data  <= w_sum;
                            r_count <= CNT_W'(1);
                            r_sat   <= w_sat;
                        end else if (w_p_acc) begin
                            r_acc     <= w_sum;
                            r_cnt     <= CNT_W'(1);
                            r_sat_acc <= w_sat;
                            r_valid   <= 1'b0;
                            r_state   <= ACC;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= ACC;
                        end
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_mul4s_dot_acc.sv
// tb_mul4s_dot_acc: directed vectors for mul4s_dot_acc. Instance A uses the
// default ACC_W=12; instance B (ACC_W=9) shares every input and exposes
// wrap/saturation behaviour, whose expectation depends on MUL4S_ACC_SAT_EN.
module tb_mul4s_dot_acc;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              p_valid;
    logic signed [7:0] p_data;
    logic              p_last;
    logic              r_ready;

    logic              a_p_ready, a_r_valid, a_r_sat;
    logic signed [11:0] a_r_data;
    logic [3:0]        a_r_count;
    logic              b_p_ready, b_r_valid, b_r_sat;
    logic signed [8:0] b_r_data;
    logic [3:0]        b_r_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul4s_dot_acc #(.LEN(8), .ACC_W(12)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_ready(a_p_ready), .p_data(p_data), .p_last(p_last),
        .r_valid(a_r_valid), .r_ready(r_ready), .r_data(a_r_data),
        .r_count(a_r_count), .r_sat(a_r_sat)
    );

    mul4s_dot_acc #(.LEN(8), .ACC_W(9)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_ready(b_p_ready), .p_data(p_data), .p_last(p_last),
        .r_valid(b_r_valid), .r_ready(r_ready), .r_data(b_r_data),
        .r_count(b_r_count), .r_sat(b_r_sat)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one product; it must be accepted at the next edge.
    task automatic push(input int d, input logic last);
        p_valid = 1'b1;
        p_data  = 8'(d);
        p_last  = last;
        #1;
        chk("push_rdy", int'(a_p_ready), 1);
        step();
        p_valid = 1'b0;
        p_last  = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        p_valid = 1'b1;
        p_data  = 8'sd64;
        p_last  = 1'b0;
        r_ready = 1'b1;

        // Reset held 3 cycles with a product offered
        #1;
        chk("rst_rdy0", int'(a_p_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_rdy", int'(a_p_ready), 0);
            chk("rst_vld", int'(a_r_valid), 0);
            chk("rst_data", int'(a_r_data), 0);
            chk("rst_cnt", int'(a_r_count), 0);
        end
        chk("rst_sat", int'(a_r_sat), 0);
        p_valid = 1'b0;
        rst_n   = 1'b1;

        // Full sum: 8 x 64
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("full_vld_early", int'(a_r_valid), 0);
            push(64, 1'b0);
        end
        chk("full_vld", int'(a_r_valid), 1);
        chk("full_data", int'(a_r_data), 512);
        chk("full_cnt", int'(a_r_count), 8);
        chk("full_sat", int'(a_r_sat), 0);
        chk("sat9_vld", int'(b_r_valid), 1);
`ifdef MUL4S_ACC_SAT_EN
        chk("sat9_data", int'(b_r_data), 255);
        chk("sat9_flag", int'(b_r_sat), 1);
`else
        chk("wrap9_data", int'(b_r_data), 0);
        chk("wrap9_flag", int'(b_r_sat), 0);
`endif
        step();
        chk("full_drain", int'(a_r_valid), 0);

        // Early last: -56 + 10 + 20
        push(-56, 1'b0);
        push(10, 1'b0);
        push(20, 1'b1);
        chk("early_vld", int'(a_r_valid), 1);
        chk("early_data", int'(a_r_data), -26);
        chk("early_cnt", int'(a_r_count), 3);
        chk("early_b_data", int'(b_r_data), -26);
        chk("early_b_sat", int'(b_r_sat), 0);

        // Backpressure: result held, input side stalled
        r_ready = 1'b0;
        p_valid = 1'b1;
        p_data  = 8'sd99;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rdy", int'(a_p_ready), 0);
            step();
            chk("bp_vld", int'(a_r_valid), 1);
            chk("bp_data", int'(a_r_data), -26);
            chk("bp_cnt", int'(a_r_count), 3);
        end

        // Overlap: result leaves while 5 opens the next sum
        r_ready = 1'b1;
        p_data  = 8'sd5;
        #1;
        chk("ovl_rdy", int'(a_p_ready), 1);
        step();
        p_valid = 1'b0;
        chk("ovl_vld", int'(a_r_valid), 0);
        for (int i = 0; i < 7; i++) push(1, 1'b0);
        chk("ovl_sum_vld", int'(a_r_valid), 1);
        chk("ovl_sum_data", int'(a_r_data), 12);
        chk("ovl_sum_cnt", int'(a_r_count), 8);

        // Overlap with a single-term closing product: stays in OUT
        push(7, 1'b1);
        chk("one_vld", int'(a_r_valid), 1);
        chk("one_data", int'(a_r_data), 7);
        chk("one_cnt", int'(a_r_count), 1);
        step();
        chk("one_drain", int'(a_r_valid), 0);

        // p_last without p_valid is ignored
        p_last = 1'b1;
        step();
        p_last = 1'b0;
        chk("last_novld", int'(a_r_valid), 0);

        // Reset mid-sum discards 4 x 10
        for (int i = 0; i < 4; i++) push(10, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_vld", int'(a_r_valid), 0);
        for (int i = 0; i < 8; i++) push(1, 1'b0);
        chk("mid_vld", int'(a_r_valid), 1);
        chk("mid_data", int'(a_r_data), 8);
        chk("mid_cnt", int'(a_r_count), 8);
        step();
        chk("mid_drain", int'(a_r_valid), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
